// File: rtl/mem_port_arbiter.sv
// Two-port (instruction read / data read-write) arbiter for one single-port
// synchronous memory. Requests are granted combinationally from IDLE, and
// round-robin decides conflicts. Partial data writes become a read-modify-write
// that occupies the memory for one extra cycle in state RMW.
module mem_port_arbiter #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD/8-1:0] d_be,
  input  logic [ADDR-1:0]   d_addr,
  input  logic [WORD-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD-1:0]   d_rdata,
  output logic [ADDR-1:0]   mem_A,
  output logic              mem_W,
  output logic [WORD-1:0]   mem_D,
  input  logic [WORD-1:0]   mem_Q
);

  localparam int BE = WORD / 8;

  typedef enum logic [0:0] {IDLE = 1'b0, RMW = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            rr_d_last_q, rr_d_last_d;   // 1: data port was granted most recently
  logic            i_rv_q, i_rv_d;
  logic            d_rv_q, d_rv_d;
  logic [ADDR-1:0] lat_a_q, lat_a_d;
  logic [WORD-1:0] lat_w_q, lat_w_d;
  logic [BE-1:0]   lat_be_q, lat_be_d;
  logic [ADDR-1:0] hold_a_q, hold_a_d;         // last address driven to memory
  logic [WORD-1:0] hold_dat_q, hold_dat_d;     // last write data driven to memory
  logic            grant_i_s, grant_d_s;
  logic            be_full_s, be_zero_s;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [WORD-1:0] merge_bytes(input logic [WORD-1:0] old_w,
                                                  input logic [WORD-1:0] new_w,
                                                  input logic [BE-1:0]   be);
    logic [WORD-1:0] r;
    r = old_w;
    for (int k = 0; k < BE; k++) begin
      if (be[k]) begin
        r[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return r;
  endfunction

  assign be_full_s = (d_be == {BE{1'b1}});
  assign be_zero_s = (d_be == {BE{1'b0}});

  // State register and all registered bookkeeping; async reset to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_d_last_q <= 1'b0;
      i_rv_q      <= 1'b0;
      d_rv_q      <= 1'b0;
      lat_a_q     <= {ADDR{1'b0}};
      lat_w_q     <= {WORD{1'b0}};
      lat_be_q    <= {BE{1'b0}};
      hold_a_q    <= {ADDR{1'b0}};
      hold_dat_q  <= {WORD{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_d_last_q <= rr_d_last_d;
      i_rv_q      <= i_rv_d;
      d_rv_q      <= d_rv_d;
      lat_a_q     <= lat_a_d;
      lat_w_q     <= lat_w_d;
      lat_be_q    <= lat_be_d;
      hold_a_q    <= hold_a_d;
      hold_dat_q  <= hold_dat_d;
    end
  end

  // Arbitration and next-state: grants only from IDLE, round-robin on conflict.
  always_comb begin
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    state_d     = IDLE;
    rr_d_last_d = rr_d_last_q;
    lat_a_d     = lat_a_q;
    lat_w_d     = lat_w_q;
    lat_be_d    = lat_be_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (rr_d_last_q) begin
            grant_i_s = 1'b1;
          end else begin
            grant_d_s = 1'b1;
          end
        end else if (i_req) begin
          grant_i_s = 1'b1;
        end else if (d_req) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_d_s) begin
          rr_d_last_d = 1'b1;
          lat_a_d     = d_addr;
          lat_w_d     = d_wdata;
          lat_be_d    = d_be;
          if (d_we && !be_full_s && !be_zero_s) begin
            state_d = RMW;
          end else begin
            state_d = IDLE;
          end
        end else if (grant_i_s) begin
          rr_d_last_d = 1'b0;
        end else begin
          rr_d_last_d = rr_d_last_q;
        end
      end
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    i_rv_d = grant_i_s;
    d_rv_d = grant_d_s && !d_we;
  end

  // Memory-side and port-side outputs; everything forced quiet while in reset.
  always_comb begin
    mem_W = 1'b0;
    mem_A = hold_a_q;
    mem_D = hold_dat_q;
    if (!rst_n) begin
      mem_A = {ADDR{1'b0}};
      mem_D = {WORD{1'b0}};
    end else if (state_q == RMW) begin
      mem_A = lat_a_q;
      mem_W = 1'b1;
      mem_D = merge_bytes(mem_Q, lat_w_q, lat_be_q);
    end else if (grant_i_s) begin
      mem_A = i_addr;
    end else if (grant_d_s) begin
      mem_A = d_addr;
      if (d_we) begin
        mem_D = d_wdata;
        mem_W = be_full_s;
      end else begin
        mem_D = hold_dat_q;
      end
    end else begin
      mem_W = 1'b0;
    end
    hold_a_d   = mem_A;
    hold_dat_d = mem_D;
    i_gnt      = rst_n && grant_i_s;
    d_gnt      = rst_n && grant_d_s;
    i_rvalid   = i_rv_q;
    d_rvalid   = d_rv_q;
    i_rdata    = i_rv_q ? mem_Q : {WORD{1'b0}};
    d_rdata    = d_rv_q ? mem_Q : {WORD{1'b0}};
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [15:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [15:0] mem_A;
  logic        mem_W;
  logic [31:0] mem_D, mem_Q;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // memory environment with a backdoor preload port
  logic [31:0] mem [0:255];
  logic        poke_en;
  logic [7:0]  poke_a;
  logic [31:0] poke_d;

  // reference model state for the random phase
  logic [31:0] ref_mem [0:15];
  bit          busy, last_d, gi, gd, exp_w;
  bit          e_irv, e_drv;
  logic [31:0] e_ird, e_drd;

  mem_port_arbiter #(.WORD(32), .ADDR(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous single-port memory: write on mem_W, read data one cycle later
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_W) begin
      mem[mem_A[7:0]] <= mem_D;
    end
    mem_Q <= mem[mem_A[7:0]];
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    tick();
    poke_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; poke_en = 1'b0; poke_a = 8'h00; poke_d = 32'h0;
    i_req = 1'b0; i_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 16'h0; d_wdata = 32'h0;
    mem_Q = 32'h0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    #3;
    chk("reset_outputs", {i_gnt, d_gnt, mem_W, i_rvalid, d_rvalid, mem_A, mem_D},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0});
    poke(8'h01, 32'h0101_0101);
    poke(8'h02, 32'h0202_0202);
    poke(8'h10, 32'hDEAD_BEEF);
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0001; d_addr = 16'h0002;
    tick();
    chk("reset_no_grant", {i_gnt, d_gnt, mem_W, mem_A, i_rdata, d_rdata},
        {1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0});
    rst_n = 1'b1;

    // alternating grants on continuous conflict, data wins first
    #2;
    chk("rr_c0_gnt", {i_gnt, d_gnt, mem_A}, {1'b0, 1'b1, 16'h0002});
    tick(); #2;
    chk("rr_c1_gnt", {i_gnt, d_gnt, mem_A}, {1'b1, 1'b0, 16'h0001});
    chk("rr_c1_drv", {d_rvalid, d_rdata, i_rvalid}, {1'b1, 32'h0202_0202, 1'b0});
    tick(); #2;
    chk("rr_c2_gnt", {i_gnt, d_gnt}, {1'b0, 1'b1});
    chk("rr_c2_irv", {i_rvalid, i_rdata, d_rvalid}, {1'b1, 32'h0101_0101, 1'b0});
    tick(); #2;
    chk("rr_c3_gnt", {i_gnt, d_gnt}, {1'b1, 1'b0});
    tick();
    i_req = 1'b0; d_req = 1'b0; #2;
    chk("rr_c4_irv", {i_rvalid, i_rdata, i_gnt, d_gnt}, {1'b1, 32'h0101_0101, 1'b0, 1'b0});

    // full write then read back
    tick();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 16'h0005; d_wdata = 32'h1234_5678; #2;
    chk("wr_full_grant", {d_gnt, mem_W, mem_A, mem_D}, {1'b1, 1'b1, 16'h0005, 32'h1234_5678});
    tick();
    d_req = 1'b0; #2;
    chk("wr_full_one_cycle", {mem_W, d_rvalid, d_rdata}, {1'b0, 1'b0, 32'h0});
    chk("wr_full_hold", {mem_A, mem_D}, {16'h0005, 32'h1234_5678});
    tick();
    d_req = 1'b1; d_we = 1'b0; #2;
    chk("rd5_grant", {d_gnt, mem_W}, {1'b1, 1'b0});
    tick();
    d_req = 1'b0; #2;
    chk("rd5_data", {d_rvalid, d_rdata}, {1'b1, 32'h1234_5678});

    // single instruction read
    tick();
    i_req = 1'b1; i_addr = 16'h0010; #2;
    chk("ird_grant", {i_gnt, d_gnt, mem_A, mem_W}, {1'b1, 1'b0, 16'h0010, 1'b0});
    tick();
    i_req = 1'b0; #2;
    chk("ird_data", {i_rvalid, i_rdata, i_gnt}, {1'b1, 32'hDEAD_BEEF, 1'b0});

    // partial write with a competing instruction request
    tick();
    poke(8'h07, 32'hAABB_CCDD);
    i_req = 1'b1; i_addr = 16'h0003;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0101; d_addr = 16'h0007; d_wdata = 32'h1122_3344; #2;
    chk("rmw_n_grant", {d_gnt, i_gnt, mem_W, mem_A}, {1'b1, 1'b0, 1'b0, 16'h0007});
    tick();
    d_req = 1'b0; #2;
    chk("rmw_n1_write", {i_gnt, d_gnt, mem_W, mem_A, mem_D}, {1'b0, 1'b0, 1'b1, 16'h0007, 32'hAA22_CC44});
    tick(); #2;
    chk("rmw_n2_grant", {i_gnt, mem_W, mem[7]}, {1'b1, 1'b0, 32'hAA22_CC44});
    tick();
    i_req = 1'b0; #2;
    chk("rmw_n3_irv", {i_rvalid, d_rvalid}, {1'b1, 1'b0});

    // same partial write, reset pulsed in the RMW cycle
    tick();
    poke(8'h07, 32'hAABB_CCDD);
    i_req = 1'b1;
    d_req = 1'b1; #2;
    chk("rst_rmw_grant", {d_gnt, i_gnt}, {1'b1, 1'b0});
    tick();
    d_req = 1'b0; #1;
    chk("rst_rmw_pre", mem_W, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_rmw_forced", {mem_W, mem_A, mem_D, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata},
        {1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tick();
    chk("rst_rmw_mem", mem[7], 32'hAABB_CCDD);
    rst_n = 1'b1; #2;
    chk("rst_first_grant", {i_gnt, mem_A}, {1'b1, 16'h0003});
    tick();
    i_req = 1'b0;

    // zero byte-enable write
    tick();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 16'h0007; d_wdata = 32'hFFFF_FFFF; #2;
    chk("be0_grant", {d_gnt, mem_W}, {1'b1, 1'b0});
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 16'h0007; #2;
    chk("be0_next", {i_gnt, mem_W, d_rvalid}, {1'b1, 1'b0, 1'b0});
    tick();
    i_req = 1'b0; #2;
    chk("be0_mem", {i_rvalid, i_rdata}, {1'b1, 32'hAABB_CCDD});
    tick();

    // randomized run against the model
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      poke(8'(a), ref_mem[a]);
    end
    busy = 1'b0; last_d = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_ird = 32'h0; e_drd = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1'b1; i_addr = 16'($urandom_range(0, 15));
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 16'($urandom_range(0, 15));
        d_wdata = $urandom;
        case ($urandom_range(0, 3))
          0: d_be = 4'hF;
          1: d_be = 4'h0;
          default: d_be = 4'($urandom_range(1, 14));
        endcase
      end
      #2;
      gi = 1'b0; gd = 1'b0;
      if (!busy) begin
        if (i_req && d_req) begin
          gi = last_d; gd = !last_d;
        end else begin
          gi = i_req; gd = d_req;
        end
      end
      exp_w = busy || (gd && d_we && d_be == 4'hF);
      chk("rnd_gnt", {i_gnt, d_gnt}, {gi, gd});
      chk("rnd_memw", mem_W, exp_w);
      chk("rnd_irsp", {i_rvalid, i_rdata}, {e_irv, e_ird});
      chk("rnd_drsp", {d_rvalid, d_rdata}, {e_drv, e_drd});
      if (gi) chk("rnd_iaddr", mem_A, i_addr);
      if (gd) chk("rnd_daddr", mem_A, d_addr);
      e_irv = gi;
      e_ird = gi ? ref_mem[i_addr[3:0]] : 32'h0;
      e_drv = gd && !d_we;
      e_drd = (gd && !d_we) ? ref_mem[d_addr[3:0]] : 32'h0;
      if (gd && d_we) begin
        for (int k = 0; k < 4; k++) begin
          if (d_be[k]) ref_mem[d_addr[3:0]][8*k +: 8] = d_wdata[8*k +: 8];
        end
      end
      busy = gd && d_we && d_be != 4'h0 && d_be != 4'hF;
      if (gi) last_d = 1'b0;
      if (gd) last_d = 1'b1;
      tick();
      if (gi) i_req = 1'b0;
      if (gd) d_req = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    for (int a = 0; a < 16; a++) chk("rnd_mem_final", mem[a], ref_mem[a]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR, default 16, memory word-address width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_req  in  1  instruction-port read request, held until granted.
REQ-006 SHALL have port i_addr  in  ADDR  instruction-port word address.
REQ-007 SHALL have port i_gnt  out  1  one-cycle pulse; the instruction request is accepted this cycle.
REQ-008 SHALL have port i_rvalid  out  1  instruction read data is valid this cycle.
REQ-009 SHALL have port i_rdata  out  WORD  instruction read data.
REQ-010 SHALL have port d_req  in  1  data-port request, held until granted.
REQ-011 SHALL have port d_we  in  1  data-port write (1) or read (0).
REQ-012 SHALL have port d_be  in  WORD/8  data-port byte enables; bit k covers bits 8k+7:8k.
REQ-013 SHALL have port d_addr  in  ADDR  data-port word address.
REQ-014 SHALL have port d_wdata  in  WORD  data-port write data.
REQ-015 SHALL have port d_gnt  out  1  one-cycle pulse; the data request is accepted this cycle.
REQ-016 SHALL have port d_rvalid  out  1  data read data is valid this cycle (reads only).
REQ-017 SHALL have port d_rdata  out  WORD  data read data.
REQ-018 SHALL have port mem_A  out  ADDR  memory address.
REQ-019 SHALL have port mem_W  out  1  memory write strobe; 0 means read.
REQ-020 SHALL have port mem_D  out  WORD  memory write data.
REQ-021 SHALL have port mem_Q  in  WORD  memory read data, valid one cycle after a read cycle.

Function
REQ-022 SHALL drive mem_A, mem_W and mem_D combinationally in the grant cycle so the memory samples the granted operation at the closing clock edge.
REQ-023 SHALL accept at most one request per cycle, and only while the FSM is in IDLE.
REQ-024 SHALL grant immediately, in the same cycle, when exactly one port requests in IDLE.
REQ-025 SHALL arbitrate round-robin on conflict: the port not most recently granted wins; after reset the data port wins the first conflict.
REQ-026 Read (i_req, or d_req with d_we=0): grant in cycle N with mem_W=0; in cycle N+1 assert the port's rvalid with rdata = mem_Q.
REQ-027 SHALL allow back-to-back reads: a new grant in cycle N+1 is legal while the N response is returned.
REQ-028 Full write (d_we=1, d_be all ones): mem_W=1 and mem_D=d_wdata in grant cycle N; single-cycle occupancy; no rvalid.
REQ-029 Partial write (d_be neither all ones nor zero): grant in N with a memory read of d_addr (mem_W=0), then enter state RMW.
REQ-030 In RMW (cycle N+1): mem_A = latched address, mem_W=1, mem_D = per byte (be ? latched wdata : mem_Q); no grant this cycle; return to IDLE.
REQ-031 SHALL latch d_addr, d_wdata and d_be at grant for use in RMW.
REQ-032 d_be=0 write: grant, no memory write (mem_W=0), single-cycle occupancy.
REQ-033 SHALL use only two FSM states, IDLE and RMW.
REQ-034 SHALL drive rdata to 0 whenever the corresponding rvalid is 0.
REQ-035 While no operation is granted, mem_W SHALL be 0 and mem_A/mem_D SHALL hold their last driven values.
REQ-036 A read granted after an RMW to the same address SHALL return the merged value; this ordering is guaranteed because the RMW write completes before the next grant.

Reset
REQ-037 While rst_n=0, regardless of the clock: state=IDLE, i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, rdata=0, mem_W=0, mem_A=0, mem_D=0, round-robin pointer = instruction-last.
REQ-038 Reset asserted in RMW SHALL force mem_W=0 immediately, abandon the write and leave memory unchanged; any pending rvalid SHALL be dropped.
REQ-039 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-040 mem[0x0010]=0xDEADBEEF; i_req, i_addr=0x0010 -> i_gnt in cycle 0; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle 1.
REQ-041 i_req and d_req (read) asserted together after reset, held continuously -> d_gnt, i_gnt, d_gnt, ... alternating every cycle; each rvalid one cycle after its grant.
REQ-042 d write, d_be=4'hF, addr 5, data 0x12345678; then d read addr 5 -> mem_W=1 for exactly one cycle; d_rdata=0x12345678.
REQ-043 mem[7]=0xAABBCCDD; d write d_be=4'b0101, wdata 0x11223344, with i_req held -> no grant in N+1; mem_W=1 only in N+1; mem[7]=0xAA22CC44; i_gnt in N+2.
REQ-044 Same stimulus as REQ-043 with rst_n pulsed low during N+1 -> mem_W=0 immediately; mem[7] remains 0xAABBCCDD; all outputs take REQ-037 values.
REQ-045 d write with d_be=0 -> d_gnt pulse; mem_W stays 0; next request is granted the following cycle.
